// File: rtl/dm_port_arbiter.sv
// rtl/dm_port_arbiter.sv - single-port data memory arbiter between MEM stage (C) and loader/debug port (X)
//
// Purpose:
//   Shares one single-port DM between the pipeline MEM stage (port C) and an
//   external loader/debug port (port X). C has fixed priority, X is protected
//   by a starvation counter and can hold the memory for a burst with x_lock.
//   DM reads are registered, so read data returns one cycle after the grant.
//
// Ports:
//   clk, rst                      clock, asynchronous active-low reset
//   c_req/c_we/c_addr/c_wdata     C request (held until c_gnt)
//   c_pc                          C instruction PC (trace only)
//   c_gnt/c_stall                 C grant (combinational) and stall to hazard unit
//   c_rvalid/c_rdata              C read response
//   x_req/x_we/x_lock/x_addr/x_wdata  X request, x_lock keeps the grant
//   x_gnt                         X grant (combinational)
//   x_rvalid/x_rdata              X read response
//   dm_en/dm_we/dm_idx/dm_wdata   DM access strobe, write enable, word index, write data
//   dm_rdata                      DM read data, valid the cycle after dm_en
//   err                           pulse: the previous granted access was out of range
//
// Configuration:
//   DM_TRACE_EN  when defined, every granted in-range write is printed at the
//                clock edge; otherwise c_pc is unused.

module dm_port_arbiter #(
    parameter int DEPTH      = 3072,
    parameter int IDX_W      = 12,
    parameter int STARVE_MAX = 4
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             c_req,
    input  logic             c_we,
    input  logic [31:0]      c_addr,
    input  logic [31:0]      c_wdata,
    input  logic [31:0]      c_pc,
    output logic             c_gnt,
    output logic             c_stall,
    output logic             c_rvalid,
    output logic [31:0]      c_rdata,

    input  logic             x_req,
    input  logic             x_we,
    input  logic             x_lock,
    input  logic [31:0]      x_addr,
    input  logic [31:0]      x_wdata,
    output logic             x_gnt,
    output logic             x_rvalid,
    output logic [31:0]      x_rdata,

    output logic             dm_en,
    output logic             dm_we,
    output logic [IDX_W-1:0] dm_idx,
    output logic [31:0]      dm_wdata,
    input  logic [31:0]      dm_rdata,

    output logic             err
);

    localparam int          CNT_W = $clog2(STARVE_MAX + 1);
    localparam logic [31:0] LIMIT = 32'(DEPTH * 4);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CPU      = 2'd1,
        EXT      = 2'd2,
        EXT_LOCK = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   starve_q, starve_d;

    logic               any_gnt;
    logic               sel_we;
    logic [31:0]        sel_addr;
    logic [31:0]        sel_wdata;
    logic               sel_oor;

    // Read-response tags: a read was granted last cycle, and whether it was
    // out of range (then the response carries zero instead of DM data).
    logic               c_pend_q, c_oor_q;
    logic               x_pend_q, x_oor_q;
    logic [31:0]        c_rdata_q, x_rdata_q;
    logic [31:0]        c_rd_now, x_rd_now;
    logic               err_q;

    // Grant, next-state and starvation counter
    always_comb begin
        c_gnt    = 1'b0;
        x_gnt    = 1'b0;
        state_d  = IDLE;
        starve_d = starve_q;

        if (state_q == EXT_LOCK && x_req && x_lock) begin
            x_gnt = 1'b1;
        end else if (c_req && (starve_q < CNT_W'(STARVE_MAX))) begin
            c_gnt = 1'b1;
        end else if (x_req) begin
            x_gnt = 1'b1;
        end

        if (x_gnt && x_lock) begin
            state_d = EXT_LOCK;
        end else if (x_gnt) begin
            state_d = EXT;
        end else if (c_gnt) begin
            state_d = CPU;
        end

        if (x_gnt || !x_req) begin
            starve_d = '0;
        end else if (starve_q < CNT_W'(STARVE_MAX)) begin
            starve_d = starve_q + CNT_W'(1);
        end
    end

    assign c_stall = c_req & ~c_gnt;
    assign any_gnt = c_gnt | x_gnt;

    // Winner datapath mux
    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = 32'h0;
        sel_wdata = 32'h0;
        if (c_gnt) begin
            sel_we    = c_we;
            sel_addr  = c_addr;
            sel_wdata = c_wdata;
        end else if (x_gnt) begin
            sel_we    = x_we;
            sel_addr  = x_addr;
            sel_wdata = x_wdata;
        end
    end

    // Out-of-range accesses are granted (so the requester is released) but
    // never reach the array.
    assign sel_oor  = any_gnt && (sel_addr >= LIMIT);
    assign dm_en    = any_gnt & ~sel_oor;
    assign dm_we    = any_gnt & ~sel_oor & sel_we;
    assign dm_idx   = sel_addr[IDX_W+1:2];
    assign dm_wdata = sel_wdata;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            c_pend_q <= 1'b0;
            c_oor_q  <= 1'b0;
            x_pend_q <= 1'b0;
            x_oor_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            c_pend_q <= c_gnt & ~c_we;
            c_oor_q  <= c_gnt & ~c_we & sel_oor;
            x_pend_q <= x_gnt & ~x_we;
            x_oor_q  <= x_gnt & ~x_we & sel_oor;
            err_q    <= sel_oor;
        end
    end

    // The DM already registers its read data, so in the response cycle the
    // port sees dm_rdata directly; the holding register keeps it afterwards
    // until the next read on that port.
    assign c_rd_now = c_oor_q ? 32'h0 : dm_rdata;
    assign x_rd_now = x_oor_q ? 32'h0 : dm_rdata;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            c_rdata_q <= 32'h0;
            x_rdata_q <= 32'h0;
        end else begin
            if (c_pend_q) begin
                c_rdata_q <= c_rd_now;
            end
            if (x_pend_q) begin
                x_rdata_q <= x_rd_now;
            end
        end
    end

    assign c_rvalid = c_pend_q;
    assign x_rvalid = x_pend_q;
    assign c_rdata  = c_pend_q ? c_rd_now : c_rdata_q;
    assign x_rdata  = x_pend_q ? x_rd_now : x_rdata_q;
    assign err      = err_q;

`ifdef DM_TRACE_EN
    logic [31:0] trace_pc;
    assign trace_pc = c_gnt ? c_pc : 32'h0;

    always @(posedge clk) begin
        if (rst && any_gnt && !sel_oor && sel_we) begin
            $display("%d@%h: *%h <= %h", $time, trace_pc, sel_addr, sel_wdata);
        end
    end
`else
    logic unused_pc;
    assign unused_pc = ^c_pc;
`endif

    // Byte-lane bits are ignored by a word-addressed DM.
    logic unused_lane;
    assign unused_lane = ^{c_addr[1:0], x_addr[1:0]};

endmodule

// File: tb/tb_dm_port_arbiter.sv
// tb/tb_dm_port_arbiter.sv - scoreboard testbench for dm_port_arbiter
module tb_dm_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        c_req, c_we;
    logic [31:0] c_addr, c_wdata, c_pc;
    logic        c_gnt, c_stall, c_rvalid;
    logic [31:0] c_rdata;
    logic        x_req, x_we, x_lock;
    logic [31:0] x_addr, x_wdata;
    logic        x_gnt, x_rvalid;
    logic [31:0] x_rdata;
    logic        dm_en, dm_we;
    logic [11:0] dm_idx;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;
    logic        err;

    int checks   = 0;
    int failures = 0;

    logic [31:0] mem    [0:3071];
    logic [31:0] shadow [0:3071];
    logic [31:0] cq[$];
    logic [31:0] xq[$];

    always #5 clk = ~clk;

    dm_port_arbiter dut (
        .clk(clk), .rst(rst),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata), .c_pc(c_pc),
        .c_gnt(c_gnt), .c_stall(c_stall), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
        .x_req(x_req), .x_we(x_we), .x_lock(x_lock), .x_addr(x_addr), .x_wdata(x_wdata),
        .x_gnt(x_gnt), .x_rvalid(x_rvalid), .x_rdata(x_rdata),
        .dm_en(dm_en), .dm_we(dm_we), .dm_idx(dm_idx), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .err(err)
    );

    // Data memory model: registered read, write on dm_en & dm_we
    always @(posedge clk) begin
        if (dm_en && dm_idx < 12'd3072) begin
            if (dm_we) mem[dm_idx] <= dm_wdata;
            else       dm_rdata    <= mem[dm_idx];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Response monitor: pops the scoreboard when a port returns read data
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            if (c_rvalid) begin
                if (cq.size() == 0) check("c_rvalid_unexpected", 32'(c_rvalid), 32'h0);
                else                check("c_rdata", c_rdata, cq.pop_front());
            end
            if (x_rvalid) begin
                if (xq.size() == 0) check("x_rvalid_unexpected", 32'(x_rvalid), 32'h0);
                else                check("x_rdata", x_rdata, xq.pop_front());
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        c_req = 0; c_we = 0; c_addr = 0; c_wdata = 0; c_pc = 0;
        x_req = 0; x_we = 0; x_lock = 0; x_addr = 0; x_wdata = 0;
    endtask

    task automatic c_drive(input logic req, input logic we, input logic [31:0] addr, input logic [31:0] wd);
        c_req = req; c_we = we; c_addr = addr; c_wdata = wd;
    endtask

    task automatic x_drive(input logic req, input logic we, input logic lk, input logic [31:0] addr, input logic [31:0] wd);
        x_req = req; x_we = we; x_lock = lk; x_addr = addr; x_wdata = wd;
    endtask

    initial begin
        logic [31:0] bdata;
        int          beat;
        bit          expc;
        bit          expx;

        for (int i = 0; i < 3072; i++) begin
            mem[i]    = 32'hC0DE_0000 ^ (32'(i) * 32'h0001_0003);
            shadow[i] = 32'hC0DE_0000 ^ (32'(i) * 32'h0001_0003);
        end
        dm_rdata = 32'h0;
        rst = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_c_rvalid", 32'(c_rvalid), 0);
        check("rst_x_rvalid", 32'(x_rvalid), 0);
        check("rst_c_rdata", c_rdata, 0);
        check("rst_x_rdata", x_rdata, 0);
        check("rst_err", 32'(err), 0);
        check("rst_dm_en", 32'(dm_en), 0);
        cyc(); rst = 1'b1;

        // T1: C read of 0x10
        cyc(); c_drive(1, 0, 32'h10, 0);
        @(negedge clk);
        check("t1_c_gnt", 32'(c_gnt), 1);
        check("t1_x_gnt", 32'(x_gnt), 0);
        check("t1_c_stall", 32'(c_stall), 0);
        check("t1_dm_en", 32'(dm_en), 1);
        check("t1_dm_we", 32'(dm_we), 0);
        check("t1_dm_idx", 32'(dm_idx), 4);
        cq.push_back(shadow[4]);
        cyc(); idle_inputs();
        @(negedge clk);
        check("t1_dm_en_idle", 32'(dm_en), 0);
        cyc();
        @(negedge clk);
        check("t1_rvalid_low", 32'(c_rvalid), 0);
        check("t1_rdata_hold", c_rdata, shadow[4]);

        // T6 stimulus: C write with PC (trace line when enabled)
        cyc(); c_drive(1, 1, 32'h4, 32'hDEADBEEF); c_pc = 32'h3000;
        @(negedge clk);
        check("t6_dm_we", 32'(dm_we), 1);
        check("t6_dm_wdata", dm_wdata, 32'hDEADBEEF);
        shadow[1] = 32'hDEADBEEF;

        // X write then unaligned X read of the same word
        cyc(); idle_inputs(); x_drive(1, 1, 0, 32'h20, 32'h12345678);
        @(negedge clk);
        check("x_wr_gnt", 32'(x_gnt), 1);
        check("x_wr_dm_we", 32'(dm_we), 1);
        check("x_wr_dm_idx", 32'(dm_idx), 8);
        check("x_wr_dm_wdata", dm_wdata, 32'h12345678);
        shadow[8] = 32'h12345678;
        cyc(); x_drive(1, 0, 0, 32'h23, 0);
        @(negedge clk);
        check("x_rd_gnt", 32'(x_gnt), 1);
        check("x_rd_dm_idx", 32'(dm_idx), 8);
        xq.push_back(shadow[8]);
        cyc(); idle_inputs(); c_drive(1, 0, 32'h4, 0);
        @(negedge clk);
        cq.push_back(shadow[1]);
        cyc(); idle_inputs();

        // T2: starvation guard, both held 6 cycles
        for (int i = 0; i < 6; i++) begin
            cyc(); c_drive(1, 0, 32'h40, 0); x_drive(1, 0, 0, 32'h44, 0);
            @(negedge clk);
            expc = (i != 4);
            check($sformatf("t2_c_gnt_%0d", i), 32'(c_gnt), 32'(expc));
            check($sformatf("t2_x_gnt_%0d", i), 32'(x_gnt), 32'(!expc));
            check($sformatf("t2_c_stall_%0d", i), 32'(c_stall), 32'(!expc));
            if (expc) cq.push_back(shadow[16]);
            else      xq.push_back(shadow[17]);
        end
        cyc(); idle_inputs();

        // T3: locked 3-beat X write burst against a continuous C request
        beat = 0;
        for (int i = 0; i < 8; i++) begin
            cyc(); c_drive(1, 0, 32'h40, 0);
            bdata = 32'hB000_0000 + 32'(beat);
            if (beat < 3) x_drive(1, 1, 1, 32'h100 + 32'(beat * 4), bdata);
            else          x_drive(0, 0, 0, 0, 0);
            @(negedge clk);
            expx = (i >= 4 && i <= 6);
            check($sformatf("t3_x_gnt_%0d", i), 32'(x_gnt), 32'(expx));
            check($sformatf("t3_c_gnt_%0d", i), 32'(c_gnt), 32'(!expx));
            check($sformatf("t3_c_stall_%0d", i), 32'(c_stall), 32'(expx));
            if (expx) begin
                check($sformatf("t3_wdata_%0d", beat), dm_wdata, bdata);
                shadow[64 + beat] = bdata;
                beat++;
            end else begin
                cq.push_back(shadow[16]);
            end
        end
        cyc(); idle_inputs(); c_drive(1, 0, 32'h104, 0);
        @(negedge clk);
        cq.push_back(shadow[65]);
        cyc(); idle_inputs();

        // T4: range check at DEPTH*4 and just below
        cyc(); c_drive(1, 1, 32'h3000, 32'hFFFF_FFFF);
        @(negedge clk);
        check("t4_wr_gnt", 32'(c_gnt), 1);
        check("t4_wr_dm_en", 32'(dm_en), 0);
        check("t4_wr_dm_we", 32'(dm_we), 0);
        cyc(); c_drive(1, 0, 32'h3000, 0);
        @(negedge clk);
        check("t4_err_wr", 32'(err), 1);
        check("t4_rd_dm_en", 32'(dm_en), 0);
        cq.push_back(32'h0);
        cyc(); c_drive(1, 0, 32'h2FFC, 0);
        @(negedge clk);
        check("t4_err_rd", 32'(err), 1);
        check("t4_last_dm_en", 32'(dm_en), 1);
        check("t4_last_idx", 32'(dm_idx), 3071);
        cq.push_back(shadow[3071]);
        cyc(); idle_inputs();
        @(negedge clk);
        check("t4_err_clear", 32'(err), 0);

        // T5: reset during a pending locked X read
        cyc(); x_drive(1, 0, 1, 32'h10, 0);
        @(negedge clk);
        check("t5_x_gnt", 32'(x_gnt), 1);
        #1 rst = 1'b0;
        @(posedge clk); #1 idle_inputs();
        @(posedge clk); #2 rst = 1'b1;
        @(negedge clk);
        check("t5_x_rvalid", 32'(x_rvalid), 0);
        check("t5_c_rvalid", 32'(c_rvalid), 0);
        check("t5_x_rdata", x_rdata, 0);
        check("t5_c_rdata", c_rdata, 0);
        check("t5_err", 32'(err), 0);
        cyc(); c_drive(1, 0, 32'h10, 0); x_drive(1, 0, 1, 32'h10, 0);
        @(negedge clk);
        check("t5_x_rvalid_after", 32'(x_rvalid), 0);
        check("t5_state_idle_c_gnt", 32'(c_gnt), 1);
        cq.push_back(shadow[4]);
        cyc(); idle_inputs();
        cyc();
        @(negedge clk);
        check("cq_drained", 32'(cq.size()), 0);
        check("xq_drained", 32'(xq.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
